// File: rtl/proc_ctrl_pkg.sv
// proc_ctrl_pkg: shared state type and width constants for the processor run controller
package proc_ctrl_pkg;
    localparam int DATA_W_DEFAULT = 16;
    localparam int INST_W = 32;
    typedef enum logic [1:0] {IDLE, HOLD, RUN} state_t;
endpackage

// File: rtl/run_timer.sv
// run_timer: HOLD down-counter and saturating RUN-cycle counter for proc_run_controller
module run_timer
    import proc_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic              hold_en,
    input  logic              run_en,
    output logic              hold_done,
    output logic [INST_W-1:0] run_cycles
);
    logic [3:0] hold_cnt;

    assign hold_done = hold_cnt == 4'd0;

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_cnt   <= '0;
            run_cycles <= '0;
        end else if (load) begin
            hold_cnt   <= 4'(RESET_CYCLES - 1);
            run_cycles <= '0;
        end else begin
            if (hold_en && !hold_done) hold_cnt <= hold_cnt - 4'd1;
            if (run_en && run_cycles != '1) run_cycles <= run_cycles + INST_W'(1);
        end
    end
endmodule

// File: rtl/proc_run_controller.sv
// proc_run_controller: sequences one processor run (reset hold, run, capture on halt or budget)
module proc_run_controller
    import proc_ctrl_pkg::*;
#(
    parameter int RESET_CYCLES = 2,
    parameter int DATA_W       = DATA_W_DEFAULT
) (
    input  logic              CLK,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] arg0,
    input  logic [DATA_W-1:0] arg1,
    input  logic [INST_W-1:0] max_insts,
    input  logic              halt,
    input  logic [INST_W-1:0] inst_count,
    input  logic [DATA_W-1:0] top_of_stack,
    input  logic [DATA_W-1:0] second_of_stack,
    output logic              proc_reset,
    output logic [DATA_W-1:0] getin,
    output logic [DATA_W-1:0] getin2,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic [DATA_W-1:0] result,
    output logic [DATA_W-1:0] result2,
    output logic [INST_W-1:0] run_cycles
);
    state_t state;
    logic   hold_done;
    logic   accept;
    logic   budget_hit;

    assign accept     = state == IDLE && start;
    assign budget_hit = max_insts != '0 && inst_count >= max_insts;

    run_timer #(.RESET_CYCLES(RESET_CYCLES)) u_timer (
        .clk       (CLK),
        .rst       (reset),
        .load      (accept),
        .hold_en   (state == HOLD),
        .run_en    (state == RUN),
        .hold_done (hold_done),
        .run_cycles(run_cycles)
    );

    always_ff @(posedge CLK) begin
        if (reset) begin
            state      <= IDLE;
            proc_reset <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            timeout    <= 1'b0;
            getin      <= '0;
            getin2     <= '0;
            result     <= '0;
            result2    <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    getin   <= arg0;
                    getin2  <= arg1;
                    timeout <= 1'b0;
                    busy    <= 1'b1;
                    state   <= HOLD;
                end
                HOLD: if (hold_done) begin
                    proc_reset <= 1'b0;
                    state      <= RUN;
                end
                RUN: if (halt || budget_hit) begin
                    // halt wins over a simultaneous budget hit
                    result     <= top_of_stack;
                    result2    <= second_of_stack;
                    timeout    <= !halt;
                    done       <= 1'b1;
                    busy       <= 1'b0;
                    proc_reset <= 1'b1;
                    state      <= IDLE;
                end
                default: begin
                    proc_reset <= 1'b1;
                    busy       <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_proc_run_controller.sv
// tb_proc_run_controller: scoreboard bench for proc_run_controller
module tb_proc_run_controller;
    typedef struct packed {
        logic [15:0] r;
        logic [15:0] r2;
        logic        to;
        logic [31:0] rc;
    } exp_t;

    logic        CLK = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] arg0 = '0, arg1 = '0, top_of_stack = '0, second_of_stack = '0;
    logic [31:0] max_insts = '0, inst_count = '0;
    logic        proc_reset, busy, done, timeout;
    logic [15:0] getin, getin2, result, result2;
    logic [31:0] run_cycles;

    exp_t sb[$];
    int   checks = 0;
    int   passed = 0;
    int   done_seen = 0;

    proc_run_controller #(.RESET_CYCLES(2), .DATA_W(16)) dut (
        .CLK            (CLK),
        .reset          (reset),
        .start          (start),
        .arg0           (arg0),
        .arg1           (arg1),
        .max_insts      (max_insts),
        .halt           (halt),
        .inst_count     (inst_count),
        .top_of_stack   (top_of_stack),
        .second_of_stack(second_of_stack),
        .proc_reset     (proc_reset),
        .getin          (getin),
        .getin2         (getin2),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .result         (result),
        .result2        (result2),
        .run_cycles     (run_cycles)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge CLK);
    endtask

    always @(negedge CLK) begin
        if (done === 1'b1) begin
            exp_t e;
            done_seen++;
            check("sb_nonempty", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("sb_result", 32'(result), 32'(e.r));
                check("sb_result2", 32'(result2), 32'(e.r2));
                check("sb_timeout", 32'(timeout), 32'(e.to));
                check("sb_run_cycles", run_cycles, e.rc);
            end
        end
    end

    // one run: n RUN cycles, inst_count ramps 0..n-1, capture on the n-th RUN edge
    task automatic run_job(input logic [15:0] a0, input logic [15:0] a1, input logic [31:0] mi,
                           input int n, input logic use_halt, input logic hold_start);
        exp_t e;
        start = 1'b1; arg0 = a0; arg1 = a1; max_insts = mi; inst_count = '0; halt = 1'b0;
        e.r = a0 + 16'd3; e.r2 = a1; e.to = !use_halt; e.rc = 32'(n);
        sb.push_back(e);
        step(1);
        start = 1'b0;
        check("hold_getin", 32'(getin), 32'(a0));
        check("hold_getin2", 32'(getin2), 32'(a1));
        check("hold_busy", 32'(busy), 32'd1);
        check("hold_preset1", 32'(proc_reset), 32'd1);
        check("hold_clr_cycles", run_cycles, 32'd0);
        check("hold_clr_timeout", 32'(timeout), 32'd0);
        step(1);
        check("hold_preset2", 32'(proc_reset), 32'd1);
        step(1);
        check("run_preset", 32'(proc_reset), 32'd0);
        for (int i = 1; i <= n; i++) begin
            check("run_cycles_mid", run_cycles, 32'(i - 1));
            check("run_busy", 32'(busy), 32'd1);
            inst_count = 32'(i - 1);
            halt = use_halt && i == n;
            top_of_stack = (i == n) ? a0 + 16'd3 : 16'hdead;
            second_of_stack = (i == n) ? a1 : 16'hbeef;
            if (i == 2) begin
                start = 1'b1; arg0 = 16'h0001; arg1 = 16'h0002;
            end else start = hold_start && i == n;
            step(1);
        end
        halt = 1'b0;
        check("done_pulse", 32'(done), 32'd1);
        check("done_busy", 32'(busy), 32'd0);
        check("done_preset", 32'(proc_reset), 32'd1);
        check("ignored_start", 32'(getin), 32'(a0));
        check("ignored_start2", 32'(getin2), 32'(a1));
        if (!hold_start) start = 1'b0;
    endtask

    initial begin
        step(1);
        check("rst_preset", 32'(proc_reset), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_timeout", 32'(timeout), 32'd0);
        check("rst_getin", 32'(getin), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_cycles", run_cycles, 32'd0);
        reset = 1'b0;
        run_job(16'h13b0, 16'h0003, 32'd0, 7, 1'b1, 1'b0);
        step(2);
        check("hold_result", 32'(result), 32'h13b3);
        check("hold_result2", 32'(result2), 32'd3);
        check("hold_cycles", run_cycles, 32'd7);
        check("hold_to", 32'(timeout), 32'd0);
        check("idle_done", 32'(done), 32'd0);
        run_job(16'h0a0a, 16'h0005, 32'd5, 6, 1'b0, 1'b1);
        run_job(16'h2222, 16'h0007, 32'd4, 5, 1'b1, 1'b0);
        step(1);
        check("post_done", 32'(done), 32'd0);
        check("post_to", 32'(timeout), 32'd0);
        start = 1'b1; arg0 = 16'h5555; arg1 = 16'h0001; max_insts = '0;
        step(1);
        start = 1'b0;
        step(4);
        check("mid_run", 32'(proc_reset), 32'd0);
        reset = 1'b1; halt = 1'b1; top_of_stack = 16'h7777;
        step(1);
        reset = 1'b0; halt = 1'b0;
        check("mrst_preset", 32'(proc_reset), 32'd1);
        check("mrst_busy", 32'(busy), 32'd0);
        check("mrst_done", 32'(done), 32'd0);
        check("mrst_getin", 32'(getin), 32'd0);
        check("mrst_getin2", 32'(getin2), 32'd0);
        check("mrst_result", 32'(result), 32'd0);
        check("mrst_result2", 32'(result2), 32'd0);
        check("mrst_cycles", run_cycles, 32'd0);
        step(2);
        check("mrst_nodone", 32'(done), 32'd0);
        check("sb_drained", 32'(sb.size()), 32'd0);
        check("done_count", 32'(done_seen), 32'd3);
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/proc_run_controller.md
PROC_RUN_CONTROLLER -- requirements
Module: proc_run_controller

Interface
REQ-001 SHALL have parameter RESET_CYCLES, default 2, cycles proc_reset is held after a start before RUN (legal 1..15).
REQ-002 SHALL have parameter DATA_W, default 16, width of operand and stack ports.
REQ-003 SHALL have port CLK  in  1  the single clock; all state changes on its rising edge.
REQ-004 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-005 SHALL have port start  in  1  request to run the processor once with the supplied operands.
REQ-006 SHALL have port arg0  in  DATA_W  operand driven onto getin for the run.
REQ-007 SHALL have port arg1  in  DATA_W  operand driven onto getin2 for the run.
REQ-008 SHALL have port max_insts  in  32  instruction budget; 0 = unlimited.
REQ-009 SHALL have port halt  in  1  processor halted indication.
REQ-010 SHALL have port inst_count  in  32  processor instruction counter.
REQ-011 SHALL have ports top_of_stack, second_of_stack  in  DATA_W  processor stack outputs.
REQ-012 SHALL have port proc_reset  out  1  reset to the processor.
REQ-013 SHALL have ports getin, getin2  out  DATA_W  registered operands to the processor.
REQ-014 SHALL have ports busy  out  1, done  out  1, timeout  out  1  run status.
REQ-015 SHALL have ports result, result2  out  DATA_W  captured stack values; run_cycles  out  32  RUN-state cycle count.

Function
REQ-016 SHALL implement states IDLE, HOLD, RUN; busy = 1 in HOLD and RUN only.
REQ-017 SHALL drive proc_reset = 1 in IDLE and HOLD, 0 only in RUN.
REQ-018 In IDLE, start = 1 at an edge SHALL latch arg0/arg1 into getin/getin2, clear run_cycles and timeout, and enter HOLD.
REQ-019 SHALL remain in HOLD exactly RESET_CYCLES cycles, then enter RUN; getin/getin2 stable throughout.
REQ-020 SHALL ignore start while busy; operands are not re-latched.
REQ-021 In RUN, run_cycles SHALL increment by 1 per cycle, saturating at 32'hFFFF_FFFF.
REQ-022 In RUN, halt = 1 at an edge SHALL capture top_of_stack/second_of_stack into result/result2, set timeout = 0, and enter IDLE.
REQ-023 In RUN, max_insts != 0 and inst_count >= max_insts (unsigned) with halt = 0 SHALL capture as REQ-022, set timeout = 1, and enter IDLE.
REQ-024 halt and budget exhaustion in the same cycle SHALL be treated as halt (timeout = 0).
REQ-025 done SHALL be a registered one-cycle pulse in the first IDLE cycle after a capture.
REQ-026 start asserted during the done cycle SHALL be accepted (back-to-back runs).
REQ-027 result, result2, timeout, run_cycles SHALL hold their values until the next accepted start.

Reset
REQ-028 reset = 1 SHALL, at the next edge and from any state including mid-run, force state IDLE, proc_reset 1, busy 0, done 0, timeout 0, getin/getin2/result/result2 0, run_cycles 0.
REQ-029 reset SHALL take priority over start, halt and budget in the same cycle.

Structure
REQ-030 A shared package proc_ctrl_pkg SHALL hold the state enum and the DATA_W default and INST_W = 32 constants.
REQ-031 The HOLD down-counter and run_cycles saturating counter SHALL live in one sub-module run_timer; the FSM stays in proc_run_controller.

Verification
REQ-032 reset 1 cycle, then start with arg0 = 'h13b0, arg1 = 3, max_insts 0 -> getin = 'h13b0, getin2 = 3, proc_reset high exactly 2 cycles after start, then low.
REQ-033 halt raised after 7 RUN cycles with top_of_stack = 'h13b3, second_of_stack = 3 -> result = 'h13b3, result2 = 3, run_cycles = 7, timeout = 0, done one cycle, busy 0.
REQ-034 max_insts = 5, inst_count ramps 0..5, halt 0 -> capture when inst_count = 5, timeout = 1, done pulse.
REQ-035 halt = 1 and inst_count = max_insts = 4 same cycle -> timeout = 0.
REQ-036 start pulsed mid-RUN with arg0 = 'h0001 -> ignored, getin remains 'h13b0; reset mid-RUN -> all outputs per REQ-028 next cycle, no done pulse.
REQ-037 start held high through done cycle -> second run begins immediately, HOLD entered the cycle after done.
